pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. Drives the enable and synchronous-clear inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. Resolves load-use hazards, EX-stage branch/jump redirects, multi-cycle data-memory waits and HALT. Purely a sequencer; holds no datapath state.

---
 rtl/pipe_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, EX redirect, data-memory wait and HALT.
// Optional build macro PIPE_PERF_CNT_EN adds stall_cycles / flush_count performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned REG_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idex_memrd,
    input  logic             idex_regwr,
    input  logic [REG_W-1:0] idex_rd,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_rs_vld,
    input  logic             ifid_rt_vld,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_stall,
    input  logic             mem_done,
    input  logic             halt_in,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halted,
    output logic             mem_err
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [15:0]      stall_cycles,
    output logic [15:0]      flush_count
`endif
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MEMWAIT = 2'd1;
    localparam logic [1:0] ST_HALT    = 2'd2;

    localparam logic [7:0] TIMEOUT_V = 8'(MEM_TIMEOUT);

    logic [1:0] state, state_nxt;
    logic [7:0] timer, timer_nxt;
    logic       err_nxt;
    logic       mem_hold;
    logic       load_use;
    logic       redirect_flush;

    assign mem_hold = mem_req & mem_stall & ~mem_done;
    assign load_use = idex_memrd & idex_regwr &
                      ((ifid_rs_vld & (ifid_rs == idex_rd)) |
                       (ifid_rt_vld & (ifid_rt == idex_rd)));

    always_comb begin
        pc_en          = 1'b1;
        ifid_en        = 1'b1;
        idex_en        = 1'b1;
        exmem_en       = 1'b1;
        memwb_en       = 1'b1;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        exmem_flush    = 1'b0;
        memwb_flush    = 1'b0;
        redirect_flush = 1'b0;
        state_nxt      = state;
        timer_nxt      = timer;
        err_nxt        = mem_err;

        case (state)
            ST_RUN: begin
                if (halt_in) begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
                    state_nxt = ST_HALT;
                end else if (mem_hold) begin
                    {pc_en, ifid_en, idex_en, exmem_en} = '0;
                    memwb_flush = 1'b1;
                    timer_nxt   = 8'd1;
                    state_nxt   = ST_MEMWAIT;
                end else if (ex_redirect) begin
                    ifid_flush     = 1'b1;
                    idex_flush     = 1'b1;
                    redirect_flush = 1'b1;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            ST_MEMWAIT: begin
                if (mem_done) begin
                    if (ex_redirect) begin
                        ifid_flush     = 1'b1;
                        idex_flush     = 1'b1;
                        redirect_flush = 1'b1;
                    end
                    timer_nxt = '0;
                    state_nxt = ST_RUN;
                end else begin
                    {pc_en, ifid_en, idex_en, exmem_en} = '0;
                    memwb_flush = 1'b1;
                    // Timeout compare uses the pre-increment value; timer saturates instead of wrapping.
                    if (timer == TIMEOUT_V) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_HALT;
                    end else if (timer != '1) begin
                        timer_nxt = timer + 8'd1;
                    end
                end
            end
            ST_HALT: begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
            end
            default: begin
                state_nxt = ST_RUN;
                timer_nxt = '0;
            end
        endcase

        if (!rst) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en}     = '0;
            {ifid_flush, idex_flush, exmem_flush, memwb_flush} = '1;
            redirect_flush = 1'b0;
        end
    end

    assign halted = rst & (state == ST_HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_RUN;
            timer   <= '0;
            mem_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            mem_err <= err_nxt;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic stall_hit;

    assign stall_hit = ~pc_en & ((state == ST_RUN) | (state == ST_MEMWAIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_hit && stall_cycles != '1) stall_cycles <= stall_cycles + 16'd1;
            if (redirect_flush && flush_count != '1) flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table for single-cycle RUN decisions plus
// hand-written multi-cycle sequences, checked through an expected-value scoreboard queue.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       memrd;
        logic       regwr;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [2:0] rt;
        logic       rs_vld;
        logic       rt_vld;
        logic       redirect;
        logic       mreq;
        logic       mstall;
        logic       mdone;
        logic       halt;
    } in_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [10:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [10:0] exp;
    } sb_t;

    // {pc,ifid,idex,exmem,memwb enables}, {ifid,idex,exmem,memwb flushes}, halted, mem_err
    localparam logic [10:0] O_RESET  = {5'b00000, 4'b1111, 1'b0, 1'b0};
    localparam logic [10:0] O_IDLE   = {5'b11111, 4'b0000, 1'b0, 1'b0};
    localparam logic [10:0] O_LU     = {5'b00111, 4'b0100, 1'b0, 1'b0};
    localparam logic [10:0] O_REDIR  = {5'b11111, 4'b1100, 1'b0, 1'b0};
    localparam logic [10:0] O_FREEZE = {5'b00001, 4'b0001, 1'b0, 1'b0};
    localparam logic [10:0] O_HALTIN = {5'b00000, 4'b0000, 1'b0, 1'b0};
    localparam logic [10:0] O_HALTED = {5'b00000, 4'b0000, 1'b1, 1'b0};
    localparam logic [10:0] O_TMOUT  = {5'b00000, 4'b0000, 1'b1, 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b0;
    in_t  cur = '0;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic halted, mem_err;
    logic [10:0] outv;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    sb_t sb_q[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .REG_W(3)) dut (
        .clk(clk), .rst(rst),
        .idex_memrd(cur.memrd), .idex_regwr(cur.regwr), .idex_rd(cur.rd),
        .ifid_rs(cur.rs), .ifid_rt(cur.rt),
        .ifid_rs_vld(cur.rs_vld), .ifid_rt_vld(cur.rt_vld),
        .ex_redirect(cur.redirect), .mem_req(cur.mreq), .mem_stall(cur.mstall),
        .mem_done(cur.mdone), .halt_in(cur.halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .halted(halted), .mem_err(mem_err)
    );

    assign outv = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_flush, exmem_flush, memwb_flush, halted, mem_err};

    function automatic in_t mk(input logic memrd, input logic regwr, input logic [2:0] rd,
                               input logic [2:0] rs, input logic [2:0] rt,
                               input logic rs_vld, input logic rt_vld, input logic redirect,
                               input logic mreq, input logic mstall, input logic mdone,
                               input logic halt);
        in_t v;
        v.memrd = memrd; v.regwr = regwr; v.rd = rd; v.rs = rs; v.rt = rt;
        v.rs_vld = rs_vld; v.rt_vld = rt_vld; v.redirect = redirect;
        v.mreq = mreq; v.mstall = mstall; v.mdone = mdone; v.halt = halt;
        return v;
    endfunction

    task automatic sample_check();
        sb_t e;
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_empty: got outputs %b with no expectation queued", outv);
        end else begin
            e = sb_q.pop_front();
            vectors++;
            if (outv !== e.exp) begin
                miscompares++;
                $display("FAIL %s: got %b expected %b", e.name, outv, e.exp);
            end
        end
    endtask

    // One pipeline cycle: drive after the edge, queue the expectation, sample mid-cycle.
    task automatic apply(input string name, input in_t v, input logic [10:0] exp);
        sb_t e;
        @(posedge clk);
        #1;
        cur = v;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
        #3;
        sample_check();
    endtask

    // Assert reset mid-cycle, check the immediate override, release after two edges.
    task automatic reset_pulse(input string name);
        sb_t e;
        @(posedge clk);
        #2;
        cur = '0;
        rst = 1'b0;
        e.name = name;
        e.exp  = O_RESET;
        sb_q.push_back(e);
        #1;
        sample_check();
        @(posedge clk);
        @(posedge clk);
        #1;
        e.name = {name, "_held"};
        sb_q.push_back(e);
        sample_check();
        rst = 1'b1;
    endtask

    vec_t tbl[$];
    in_t  idle_v, stall_v, lu_v;

    initial begin
        idle_v  = '0;
        stall_v = mk(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1, 1, 0, 0);
        lu_v    = mk(1, 1, 3'd3, 3'd3, 3'd0, 1, 0, 0, 0, 0, 0, 0);

        tbl.push_back('{"idle",         idle_v,                                        O_IDLE});
        tbl.push_back('{"lu_rs",        lu_v,                                          O_LU});
        tbl.push_back('{"lu_rt",        mk(1, 1, 3'd5, 3'd1, 3'd5, 0, 1, 0, 0, 0, 0, 0), O_LU});
        tbl.push_back('{"lu_rs_novld",  mk(1, 1, 3'd3, 3'd3, 3'd0, 0, 0, 0, 0, 0, 0, 0), O_IDLE});
        tbl.push_back('{"lu_rt_novld",  mk(1, 1, 3'd5, 3'd1, 3'd5, 1, 0, 0, 0, 0, 0, 0), O_IDLE});
        tbl.push_back('{"lu_rd_miss",   mk(1, 1, 3'd6, 3'd3, 3'd4, 1, 1, 0, 0, 0, 0, 0), O_IDLE});
        tbl.push_back('{"lu_not_load",  mk(0, 1, 3'd3, 3'd3, 3'd0, 1, 0, 0, 0, 0, 0, 0), O_IDLE});
        tbl.push_back('{"lu_no_wr",     mk(1, 0, 3'd3, 3'd3, 3'd0, 1, 0, 0, 0, 0, 0, 0), O_IDLE});
        tbl.push_back('{"redirect",     mk(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, 0, 0, 0, 0), O_REDIR});
        tbl.push_back('{"redir_lu",     mk(1, 1, 3'd3, 3'd3, 3'd0, 1, 0, 1, 0, 0, 0, 0), O_REDIR});
        tbl.push_back('{"mem_zero_wait", mk(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1, 1, 1, 0), O_IDLE});
        tbl.push_back('{"mem_stall_noreq", mk(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 1, 0, 0), O_IDLE});
        tbl.push_back('{"mem_req_only", mk(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1, 0, 0, 0), O_IDLE});

        // Reset then idle
        @(posedge clk);
        @(posedge clk);
        #1;
        sb_q.push_back('{"reset_state", O_RESET});
        sample_check();
        rst = 1'b1;
        apply("idle_after_reset", idle_v, O_IDLE);

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i].name, tbl[i].in, tbl[i].exp);

        // Load-use lasts one cycle: the bubble clears idex_memrd
        apply("lu_first", lu_v, O_LU);
        apply("lu_bubble", mk(0, 0, 3'd0, 3'd3, 3'd0, 1, 0, 0, 0, 0, 0, 0), O_IDLE);

        // Memory wait: 4 frozen cycles (done lands exactly at timer==MEM_TIMEOUT)
        apply("mw_stall", stall_v, O_FREEZE);
        apply("mw_wait1", stall_v, O_FREEZE);
        apply("mw_wait2_ignore_evt", mk(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, 1, 1, 0, 1), O_FREEZE);
        apply("mw_wait3", stall_v, O_FREEZE);
        apply("mw_done", mk(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1, 0, 1, 0), O_IDLE);
        apply("mw_back_run", lu_v, O_LU);

        // Redirect still applies on the release cycle
        apply("mwr_stall", stall_v, O_FREEZE);
        apply("mwr_done_redir", mk(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, 1, 0, 1, 0), O_REDIR);
        apply("mwr_back_run", idle_v, O_IDLE);

        // Timeout: stall + 4 MEMWAIT cycles without done
        apply("to_stall", stall_v, O_FREEZE);
        for (int i = 1; i <= 4; i++)
            apply($sformatf("to_wait%0d", i), stall_v, O_FREEZE);
        apply("to_halted", idle_v, O_TMOUT);
        apply("to_sticky", mk(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, 1, 0, 1, 0), O_TMOUT);
        reset_pulse("to_reset");
        apply("to_after_reset", idle_v, O_IDLE);

        // HALT beats a concurrent memory stall
        apply("halt_in", mk(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, 1, 1, 0, 1), O_HALTIN);
        apply("halt_state", idle_v, O_HALTED);
        apply("halt_hold", mk(1, 1, 3'd3, 3'd3, 3'd0, 1, 0, 1, 1, 0, 1, 0), O_HALTED);
        reset_pulse("halt_reset");
        apply("halt_after_reset", idle_v, O_IDLE);

        // Reset mid-MEMWAIT returns to RUN evaluation
        apply("mr_stall", stall_v, O_FREEZE);
        apply("mr_wait", stall_v, O_FREEZE);
        reset_pulse("mr_reset");
        apply("mr_after_reset", lu_v, O_LU);
        apply("mr_restall", stall_v, O_FREEZE);
        apply("mr_done", mk(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1, 0, 1, 0), O_IDLE);

        if (sb_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_leftover: got %0d pending expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
